conv3x3_window_mac: RTL and testbench

- Stage directly downstream of the line buffers in the ConvUnit.
- Consumes three row taps per pixel:
  - current pixel;
  - pixel delayed by one line;
  - pixel delayed by two lines.
- Assembles a 3x3 sliding window and multiplies it by a programmable signed 3x3 kernel.
- Emits one convolution result per valid window through a pipelined adder tree, with a valid strobe.
- Windows that straddle a row boundary are suppressed.

---
 rtl/conv_pkg.sv | 47 ++++
 rtl/conv3x3_adder_tree.sv | 53 +++++
 rtl/conv3x3_window_mac.sv | 112 +++++++++++
 tb/tb_conv3x3_window_mac.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, tap indices and arithmetic helpers for the 3x3 conv MAC.
// Tap index k = 3*row + col, row 0 = oldest line (top), col 0 = oldest pixel.
package conv_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int COEF_WIDTH  = 8;
  localparam int KERNEL_TAPS = 9;
  localparam int PROD_W      = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int ROW_W       = PROD_W + 2;
  localparam int OUT_W       = DATA_WIDTH + COEF_WIDTH + 5;

  typedef enum logic [3:0] {
    K_TL = 4'd0,
    K_TC = 4'd1,
    K_TR = 4'd2,
    K_ML = 4'd3,
    K_MC = 4'd4,
    K_MR = 4'd5,
    K_BL = 4'd6,
    K_BC = 4'd7,
    K_BR = 4'd8
  } coef_idx_e;

  function automatic logic signed [PROD_W-1:0] tap_mul(
    input logic        [DATA_WIDTH-1:0] px,
    input logic signed [COEF_WIDTH-1:0] cf
  );
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = PROD_W'({1'b0, px});
    b = PROD_W'(cf);
    return a * b;
  endfunction

  function automatic logic signed [ROW_W-1:0] sx_row(
    input logic signed [PROD_W-1:0] p
  );
    return ROW_W'(p);
  endfunction

  function automatic logic signed [OUT_W-1:0] sx_out(
    input logic signed [ROW_W-1:0] r
  );
    return OUT_W'(r);
  endfunction

endpackage

// File: rtl/conv3x3_adder_tree.sv
// S2 row sums and S3 final sum of the 3x3 MAC, with valid pipeline.
// CONV_RELU_EN clamps negative results to zero at S3.
module conv3x3_adder_tree
  import conv_pkg::*;
(
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          v1_i,
  input  logic [KERNEL_TAPS-1:0][PROD_W-1:0] prod_i,
  output logic signed [OUT_W-1:0]       data_o,
  output logic                          valid_o
);

  logic [2:0][ROW_W-1:0] row_d;
  logic [2:0][ROW_W-1:0] row_q;
  logic signed [OUT_W-1:0] sum_d;
  logic signed [OUT_W-1:0] res_d;
  logic v2_q;

  always_comb begin
    row_d = '0;
    for (int r = 0; r < 3; r++) begin
      row_d[r] = sx_row(prod_i[3*r])
               + sx_row(prod_i[3*r+1])
               + sx_row(prod_i[3*r+2]);
    end
    sum_d = sx_out(row_q[0])
          + sx_out(row_q[1])
          + sx_out(row_q[2]);
`ifdef CONV_RELU_EN
    res_d = sum_d[OUT_W-1] ? '0 : sum_d;
`else
    res_d = sum_d;
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      row_q   <= '0;
      v2_q    <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      row_q   <= row_d;
      v2_q    <= v1_i;
      valid_o <= v2_q;
      if (v2_q) begin
        data_o <= res_d;
      end
    end
  end

endmodule

// File: rtl/conv3x3_window_mac.sv
// 3x3 sliding window, kernel store and S1 products feeding the adder tree.
// Optional CONV_RELU_EN (in the adder tree) clamps negative results.
module conv3x3_window_mac
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH = 100,
  parameter int COL_WIDTH = 7
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    valid_in,
  input  logic                    sof_in,
  input  logic [DATA_WIDTH-1:0]   row0_in,
  input  logic [DATA_WIDTH-1:0]   row1_in,
  input  logic [DATA_WIDTH-1:0]   row2_in,
  input  logic                    lines_ready,
  input  logic                    w_we,
  input  logic [3:0]              w_addr,
  input  logic [COEF_WIDTH-1:0]   w_data,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    valid_out
);

  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(IMG_WIDTH - 1);
  localparam logic [COL_WIDTH-1:0] COL_ONE  = COL_WIDTH'(1);
  localparam logic [COL_WIDTH-1:0] COL_TWO  = COL_WIDTH'(2);

  logic [2:0][2:0][DATA_WIDTH-1:0]        win_q;
  logic [KERNEL_TAPS-1:0][COEF_WIDTH-1:0] coef_q;
  logic [KERNEL_TAPS-1:0][PROD_W-1:0]     prod_q;
  logic [COL_WIDTH-1:0] col_q;
  logic [COL_WIDTH-1:0] col_d;
  logic [COL_WIDTH-1:0] eff_col;
  logic sync_q;
  logic v0_d;
  logic v0_q;
  logic v1_q;

  // Until a sof has been seen the column count is meaningless.
  always_comb begin
    eff_col = sof_in ? '0 : col_q;
    col_d   = col_q;
    if (valid_in) begin
      if (sof_in) begin
        col_d = COL_ONE;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
      end else begin
        col_d = col_q + COL_ONE;
      end
    end
    v0_d = valid_in & lines_ready
         & (sof_in | sync_q)
         & (eff_col >= COL_TWO);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      win_q  <= '0;
      col_q  <= '0;
      sync_q <= 1'b0;
      v0_q   <= 1'b0;
    end else begin
      col_q <= col_d;
      v0_q  <= v0_d;
      if (valid_in) begin
        sync_q <= sync_q | sof_in;
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= row2_in;
        win_q[1][2] <= row1_in;
        win_q[2][2] <= row0_in;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      coef_q <= '0;
    end else if (w_we) begin
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        if (w_addr == 4'(k)) begin
          coef_q[k] <= w_data;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      prod_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= v0_q;
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        prod_q[k] <= tap_mul(win_q[k/3][k%3], coef_q[k]);
      end
    end
  end

  conv3x3_adder_tree u_tree (
    .Clk     (Clk),
    .Rst     (Rst),
    .v1_i    (v1_q),
    .prod_i  (prod_q),
    .data_o  (data_out),
    .valid_o (valid_out)
  );

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Scoreboard bench for conv3x3_window_mac against a frame-level model.
// Build with +define+CONV_RELU_EN to exercise the clamped variant.
module tb_conv3x3_window_mac;
  import conv_pkg::*;

  localparam int IMG_W = 100;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic valid_in = 1'b0;
  logic sof_in = 1'b0;
  logic lines_ready = 1'b0;
  logic w_we = 1'b0;
  logic [DATA_WIDTH-1:0] row0_in = '0;
  logic [DATA_WIDTH-1:0] row1_in = '0;
  logic [DATA_WIDTH-1:0] row2_in = '0;
  logic [3:0] w_addr = '0;
  logic [COEF_WIDTH-1:0] w_data = '0;
  logic signed [OUT_W-1:0] data_out;
  logic valid_out;

  conv3x3_window_mac #(.IMG_WIDTH(IMG_W), .COL_WIDTH(7)) dut (
    .Clk(Clk), .Rst(Rst),
    .valid_in(valid_in), .sof_in(sof_in),
    .row0_in(row0_in), .row1_in(row1_in), .row2_in(row2_in),
    .lines_ready(lines_ready),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .data_out(data_out), .valid_out(valid_out)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  // Model: kernel, last three accepted tap columns [age][row], column tracker.
  int m_coef[9];
  int m_hist[3][3];
  int m_next;
  bit m_sync;

  task automatic model_reset();
    for (int k = 0; k < 9; k++) m_coef[k] = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) m_hist[c][r] = 0;
    m_next = 0;
    m_sync = 1'b0;
  endtask

  task automatic check(string name, int got, int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Called at posedge+1; applies one cycle of stimulus and advances.
  task automatic drive(bit v, bit sof, int p0, int p1, int p2,
                       bit lr, bit we, int addr, int wd);
    int eff;
    int s;
    exp_t e;
    valid_in    = v;
    sof_in      = sof;
    row0_in     = DATA_WIDTH'(p0);
    row1_in     = DATA_WIDTH'(p1);
    row2_in     = DATA_WIDTH'(p2);
    lines_ready = lr;
    w_we        = we;
    w_addr      = 4'(addr);
    w_data      = COEF_WIDTH'(wd);
    if (we && addr >= 0 && addr < 9) m_coef[addr] = wd;
    if (v) begin
      eff = sof ? 0 : m_next;
      if (sof) m_sync = 1'b1;
      m_next = (eff + 1) % IMG_W;
      m_hist[0] = m_hist[1];
      m_hist[1] = m_hist[2];
      m_hist[2][0] = p2;
      m_hist[2][1] = p1;
      m_hist[2][2] = p0;
      if (lr && m_sync && eff >= 2) begin
        s = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            s += m_coef[3*r + c] * m_hist[c][r];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        e.val = s;
        e.cyc = cyc + 4;
        sb.push_back(e);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic set_kernel_all(int val);
    for (int k = 0; k < 9; k++) drive(0, 0, 0, 0, 0, 1, 1, k, val);
  endtask

  task automatic set_identity();
    for (int k = 0; k < 9; k++)
      drive(0, 0, 0, 0, 0, 1, 1, k, (k == int'(K_MC)) ? 1 : 0);
  endtask

  task automatic ramp_row(bit sof_first, int gap);
    for (int c = 0; c < IMG_W; c++) begin
      drive(1, sof_first && c == 0, c, c, c, 1, 0, 0, 0);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic const_row(int px);
    for (int c = 0; c < 12; c++)
      drive(1, c == 0, px, px, px, 1, 0, 0, 0);
  endtask

  task automatic rand_phase(int n);
    bit v, sof, lr, we;
    int addr, wd;
    drive(1, 1, $urandom_range(255), $urandom_range(255),
          $urandom_range(255), 1, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      v    = ($urandom_range(3) != 0);
      sof  = v && ($urandom_range(99) == 0);
      lr   = ($urandom_range(19) != 0);
      we   = ($urandom_range(15) == 0);
      addr = $urandom_range(15);
      wd   = int'($urandom_range(255)) - 128;
      drive(v, sof, $urandom_range(255), $urandom_range(255),
            $urandom_range(255), lr, we, addr, wd);
    end
  endtask

  // Monitor: every presented result is popped and compared.
  exp_t got_e;
  always @(negedge Clk) begin
    if (Rst && valid_out) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got data_out=%0d at cycle %0d, required no output",
                 $signed(data_out), cyc);
      end else begin
        got_e = sb.pop_front();
        check("result_value", int'($signed(data_out)), got_e.val);
        check("result_cycle", cyc, got_e.cyc);
      end
    end
  end

  initial begin
    bit seen;
    model_reset();
    #2 Rst = 1'b0;
    #1;
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_data_out", int'($signed(data_out)), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    idle(2);

    // Pixels without a sof after reset must never produce output.
    set_identity();
    for (int c = 0; c < 8; c++) drive(1, 0, c, c, c, 1, 0, 0, 0);
    idle(5);

    ramp_row(1, 0);
    ramp_row(0, 0);
    idle(5);

    ramp_row(1, 1);
    idle(5);

    set_kernel_all(1);
    const_row(255);
    idle(5);

    set_kernel_all(-128);
    const_row(255);
    idle(5);

    // Mid-row kernel rewrite, then an out-of-range address write.
    set_identity();
    for (int c = 0; c < IMG_W; c++) begin
      if (c == 50)      drive(1, c == 0, c, c, c, 1, 1, 4, 2);
      else if (c == 60) drive(1, 0, c, c, c, 1, 1, 12, 5);
      else              drive(1, c == 0, c, c, c, 1, 0, 0, 0);
    end
    idle(5);

    rand_phase(800);
    idle(6);
    check("drain_after_random", sb.size(), 0);

    // Reset while results are in flight.
    set_kernel_all(1);
    seen = 1'b0;
    for (int c = 0; c < 14 && !seen; c++) begin
      drive(1, c == 0, 200, 200, 200, 1, 0, 0, 0);
      seen = valid_out;
    end
    check("midstream_valid_seen", int'(seen), 1);
    Rst = 1'b0;
    #1;
    check("midreset_valid_out", int'(valid_out), 0);
    check("midreset_data_out", int'($signed(data_out)), 0);
    sb.delete();
    model_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    valid_in = 1'b0;
    set_identity();
    for (int c = 0; c < 8; c++) drive(1, 0, c, c, c, 1, 0, 0, 0);
    idle(5);
    ramp_row(1, 0);
    idle(6);
    check("final_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
